r2sdf_bf_stage: RTL
===================

Name: r2sdf_bf_stage

Overview:
- Radix-2 single-path delay-feedback (R2SDF) butterfly stage of the 256-point DIF FFT. Sits directly upstream of the twiddle complex multiplier.
- Consumes one complex sample per valid cycle and buffers the first half-frame in a feedback delay line.
- Emits a+b and a-b streams in natural stage order, each with the twiddle index the downstream multiplier must apply.

Parameters:
- TOTALBITS, 30, signed width of each real/imag component (in and out).
- DEPTH, 128, feedback delay length = half frame (N/2); power of two.
- LOGDEPTH, 7, log2(DEPTH).
- TWBITS, 8, twiddle index width (log2 of full FFT size).
- TW_STRIDE, 1, twiddle index step per difference output (2^stage index).
- SCALE, 1, 1 = divide butterfly results by 2; 0 = keep low bits (wrap).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample present this cycle.
- realin  in  TOTALBITS  signed real part.
- imagin  in  TOTALBITS  signed imaginary part.
- out_valid  out  1  output sample valid.
- realout  out  TOTALBITS  signed real result.
- imagout  out  TOTALBITS  signed imaginary result.
- tw_index  out  TWBITS  twiddle exponent k (W_N^k) for this output.
- frame_start  out  1  pulse with the first sum output (pos 0) of each frame.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values: out_valid=0, realout=imagout=0, tw_index=0, frame_start=0. Position counter=0, primed=0, delay line all zero.
- Position counter: LOGDEPTH+1 bits, advances only on in_valid, wraps 2*DEPTH-1 -> 0.
  - Counter MSB = phase.
  - Low bits = pos.
- Delay line: DEPTH-entry complex shift register (or RAM + pointer). It advances only on in_valid; no state changes when in_valid=0.
- Phase 0 (fill), pos p:
  - Push input into the delay line.
  - Output the delay-line head, which is d[p] = a-b of the previous frame.
  - tw_index = (p*TW_STRIDE) mod 2^TWBITS.
- Phase 1 (butterfly), pos p:
  - a = delay head (frame sample p), b = input (sample p+DEPTH).
  - Output s = a+b with tw_index = 0.
  - Push d = a-b into the delay line.
- Arithmetic: compute sum/diff at TOTALBITS+1 bits.
  - SCALE=1: output bits [TOTALBITS:1] (arithmetic floor /2).
  - SCALE=0: output bits [TOTALBITS-1:0] (two's-complement wrap).
- Latency: outputs are registered; the result of a valid input appears exactly 1 cycle later.
- out_valid = registered(in_valid & (phase==1 | primed)). First-frame phase-0 outputs are suppressed as garbage.
- primed: set when the counter wraps 2*DEPTH-1 -> 0. Cleared only by rst.
- Output order per frame f:
  - s[0..DEPTH-1] during f's second half.
  - Then d[0..DEPTH-1] during frame f+1's first half.
  - Diffs of the final frame emerge only when further input arrives. No self-flush: upstream streams zeros to drain.
- Stall (in_valid=0): next cycle out_valid=0. realout, imagout and tw_index hold their values; frame_start=0.
- frame_start = registered(in_valid & phase==1 & pos==0).
- Reset mid-frame: partial frame discarded, primed cleared. The next valid input is treated as sample 0 of a new first frame.
- Simultaneous rst and in_valid: rst wins and the sample is dropped.

Decomposition:
- Shared package fft_pkg: TOTALBITS, FFT_N=256, TWBITS, and a complex sample typedef {re, im}. Reused by the complex multiplier and the other stages.
- One sub-module: sdf_delay_line (parameterised DEPTH/width shift buffer with enable). The butterfly arithmetic, counter and valid logic stay in r2sdf_bf_stage.

Test Plan (DEPTH=128, TOTALBITS=30):
1. Impulse, SCALE=0: frame with x[0]=(1000,0), all else 0, then a zero frame -> s[0]=(1000,0) with frame_start=1 and tw 0; s[1..127]=0; d[0]=(1000,0) tw 0; d[1..127]=0 with tw 1..127; no out_valid during the first 128 inputs.
2. Constant, SCALE=0: x=(500,-300) for 512 valid cycles -> every sum output (1000,-600) tw 0; every diff output (0,0) with tw=p.
3. Overflow, SCALE=1: a=b=(2^29-1, -2^29) -> sum=(2^29-1, -2^29); with a=-b, diff = a.
4. Bubbles: in_valid random 50% with the constant stream of scenario 2 -> identical output sequence; out_valid exactly 1 cycle after each valid phase-1 input; outputs hold during gaps.
5. Reset mid-frame: rst at input 200 of frame 1, then a new impulse frame -> matches scenario 1 exactly, with no stale data from before reset.
6. TW_STRIDE=4, TWBITS=8: diff outputs p=0..127 -> tw_index = 4p mod 256 (e.g. p=70 -> 24).

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath sizes and the complex sample type.
// Used by the butterfly stages and the twiddle multiplier.
package fft_pkg;

    localparam int TOTALBITS = 30;
    localparam int FFT_N     = 256;
    localparam int TWBITS    = $clog2(FFT_N);

    typedef struct packed {
        logic signed [TOTALBITS-1:0] re;
        logic signed [TOTALBITS-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_delay_line.sv
// Enabled shift buffer holding one half-frame of complex samples.
// The head is the word pushed DEPTH enabled cycles ago.
module sdf_delay_line #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_head = r_mem[DEPTH-1];

endmodule

// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage (DIF FFT).
// Emits a+b in the second half-frame, a-b in the next first half.
module r2sdf_bf_stage #(
    parameter int TOTALBITS = fft_pkg::TOTALBITS,
    parameter int DEPTH     = fft_pkg::FFT_N / 2,
    parameter int LOGDEPTH  = $clog2(DEPTH),
    parameter int TWBITS    = fft_pkg::TWBITS,
    parameter int TW_STRIDE = 1,
    parameter int SCALE     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [TOTALBITS-1:0] realin,
    input  logic signed [TOTALBITS-1:0] imagin,
    output logic                        out_valid,
    output logic signed [TOTALBITS-1:0] realout,
    output logic signed [TOTALBITS-1:0] imagout,
    output logic        [TWBITS-1:0]    tw_index,
    output logic                        frame_start
);

    localparam int CW = LOGDEPTH + 1;
    localparam int W  = 2 * TOTALBITS;

    logic [CW-1:0]               r_cnt;
    logic                        r_primed;
    logic                        r_ov;
    logic                        r_fs;
    logic signed [TOTALBITS-1:0] r_re;
    logic signed [TOTALBITS-1:0] r_im;
    logic [TWBITS-1:0]           r_tw;

    logic                        w_phase;
    logic [LOGDEPTH-1:0]         w_pos;
    logic [W-1:0]                w_head;
    logic [W-1:0]                w_push;
    logic signed [TOTALBITS-1:0] w_a_re;
    logic signed [TOTALBITS-1:0] w_a_im;
    logic [TOTALBITS:0]          w_sum_re;
    logic [TOTALBITS:0]          w_sum_im;
    logic [TOTALBITS:0]          w_dif_re;
    logic [TOTALBITS:0]          w_dif_im;
    logic [TOTALBITS-1:0]        w_s_re;
    logic [TOTALBITS-1:0]        w_s_im;
    logic [TOTALBITS-1:0]        w_d_re;
    logic [TOTALBITS-1:0]        w_d_im;
    logic [TWBITS-1:0]           w_tw;

    // Scaled mode floors by 2; unscaled mode wraps to the output width.
    function automatic logic [TOTALBITS-1:0] fit(input logic [TOTALBITS:0] v);
        return (SCALE != 0) ? v[TOTALBITS:1] : v[TOTALBITS-1:0];
    endfunction

    assign w_phase = r_cnt[LOGDEPTH];
    assign w_pos   = r_cnt[LOGDEPTH-1:0];

    assign {w_a_re, w_a_im} = w_head;

    assign w_sum_re = {w_a_re[TOTALBITS-1], w_a_re} + {realin[TOTALBITS-1], realin};
    assign w_sum_im = {w_a_im[TOTALBITS-1], w_a_im} + {imagin[TOTALBITS-1], imagin};
    assign w_dif_re = {w_a_re[TOTALBITS-1], w_a_re} - {realin[TOTALBITS-1], realin};
    assign w_dif_im = {w_a_im[TOTALBITS-1], w_a_im} - {imagin[TOTALBITS-1], imagin};

    assign w_s_re = fit(w_sum_re);
    assign w_s_im = fit(w_sum_im);
    assign w_d_re = fit(w_dif_re);
    assign w_d_im = fit(w_dif_im);

    assign w_push = w_phase ? {w_d_re, w_d_im} : {realin, imagin};
    assign w_tw   = TWBITS'(32'(w_pos) * 32'(TW_STRIDE));

    sdf_delay_line #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .i_en   (in_valid),
        .i_data (w_push),
        .o_head (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
            r_ov     <= 1'b0;
            r_fs     <= 1'b0;
            r_re     <= '0;
            r_im     <= '0;
            r_tw     <= '0;
        end else begin
            r_ov <= in_valid & (w_phase | r_primed);
            r_fs <= in_valid & w_phase & (w_pos == '0);
            if (in_valid) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == '1) begin
                    r_primed <= 1'b1;
                end
                r_re <= w_phase ? w_s_re : w_a_re;
                r_im <= w_phase ? w_s_im : w_a_im;
                r_tw <= w_phase ? '0 : w_tw;
            end
        end
    end

    assign out_valid   = r_ov;
    assign frame_start = r_fs;
    assign realout     = r_re;
    assign imagout     = r_im;
    assign tw_index    = r_tw;

endmodule
